// File: rtl/alu_seq.sv
// Registered multi-cycle ALU with start/busy/done handshake.
// Shifts step one bit per cycle; MUL is shift-add over WIDTH cycles; flag_c doubles as stored carry.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_c,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] out_d, acc, acc_d, lo, lo_d, mcand, mcand_d;
  logic             n_d, z_d, v_d, c_d, done_d, err_d;
  logic [3:0]       op_q, op_d;
  logic [SHW-1:0]   cnt, cnt_d, s_raw, s_amt;

  logic [WIDTH-1:0] res, sh_val, hi_nx, lo_nx;
  logic [WIDTH:0]   arith, mul_sum;
  logic             res_c, res_v, single, sh_c, cin;

  assign busy = (state != IDLE);

  always_comb begin
    state_d = state;
    out_d   = out;
    n_d     = flag_n;
    z_d     = flag_z;
    v_d     = flag_v;
    c_d     = flag_c;
    done_d  = 1'b0;
    err_d   = 1'b0;
    acc_d   = acc;
    lo_d    = lo;
    mcand_d = mcand;
    op_d    = op_q;
    cnt_d   = cnt;
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    single  = 1'b0;
    arith   = '0;

    cin   = op[3] & flag_c;
    s_raw = in2[SHW-1:0];
    s_amt = (s_raw > SHW'(WIDTH)) ? SHW'(WIDTH) : s_raw;

    case (op_q)
      4'h4:    begin sh_val = {1'b0, acc[MSB:1]};   sh_c = acc[0];   end
      4'h5:    begin sh_val = {acc[MSB-1:0], 1'b0}; sh_c = acc[MSB]; end
      default: begin sh_val = {acc[MSB], acc[MSB:1]}; sh_c = acc[0]; end
    endcase

    // acc holds the running high half, lo the multiplier bits not yet consumed
    mul_sum = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
    hi_nx   = mul_sum[WIDTH:1];
    lo_nx   = {mul_sum[0], lo[MSB:1]};

    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            4'h0, 4'h8: begin
              arith  = {1'b0, in1} + {1'b0, in2} + (WIDTH+1)'(cin);
              res    = arith[MSB:0];
              res_c  = arith[WIDTH];
              res_v  = (in1[MSB] == in2[MSB]) && (res[MSB] != in1[MSB]);
              single = 1'b1;
            end
            4'h1, 4'h9: begin
              arith  = {1'b0, in1} - {1'b0, in2} - (WIDTH+1)'(cin);
              res    = arith[MSB:0];
              res_c  = arith[WIDTH];
              res_v  = (in1[MSB] != in2[MSB]) && (res[MSB] != in1[MSB]);
              single = 1'b1;
            end
            4'h2: begin res = in1 | in2; single = 1'b1; end
            4'h3: begin res = in1 & in2; single = 1'b1; end
            4'h6: begin res = ~in1;      single = 1'b1; end
            4'h7: begin res = in1;       single = 1'b1; end
            4'hA: begin res = in1 ^ in2; single = 1'b1; end
            4'h4, 4'h5, 4'hB: begin
              if (s_amt == '0) begin
                res    = in1;
                single = 1'b1;
              end else begin
                state_d = SHIFT;
                acc_d   = in1;
                cnt_d   = s_amt;
                op_d    = op;
              end
            end
            4'hC: begin
              state_d = MUL;
              acc_d   = '0;
              lo_d    = in2;
              mcand_d = in1;
              cnt_d   = SHW'(WIDTH);
              op_d    = op;
            end
            default: begin
              out_d  = '0;
              z_d    = 1'b1;
              done_d = 1'b1;
              err_d  = 1'b1;
            end
          endcase
          if (single) begin
            out_d  = res;
            n_d    = res[MSB];
            z_d    = (res == '0);
            v_d    = res_v;
            c_d    = res_c;
            done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        acc_d = sh_val;
        cnt_d = cnt - 1'b1;
        if (cnt == SHW'(1)) begin
          out_d   = sh_val;
          n_d     = sh_val[MSB];
          z_d     = (sh_val == '0);
          v_d     = 1'b0;
          c_d     = sh_c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d = hi_nx;
        lo_d  = lo_nx;
        cnt_d = cnt - 1'b1;
        if (cnt == SHW'(1)) begin
          out_d   = lo_nx;
          n_d     = lo_nx[MSB];
          z_d     = (lo_nx == '0);
          v_d     = 1'b0;
          c_d     = |hi_nx;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      out    <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_c <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      mcand  <= '0;
      op_q   <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_d;
      out    <= out_d;
      flag_n <= n_d;
      flag_z <= z_d;
      flag_v <= v_d;
      flag_c <= c_d;
      done   <= done_d;
      err    <= err_d;
      acc    <= acc_d;
      lo     <= lo_d;
      mcand  <= mcand_d;
      op_q   <= op_d;
      cnt    <= cnt_d;
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered, multi-cycle successor to the combinational 8-bit ALU.
- Accepts an operation through a start/busy/done handshake and latches the operands.
- Single-cycle ops complete on the accepting edge. Shifts run iteratively, one bit per cycle. Multiply runs shift-add over WIDTH cycles.
- Results and a stored NZVC flag set are registered. ADC/SBB use the stored carry for multi-word arithmetic in the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
SHW, 4, width of shift-amount field taken from in2[SHW-1:0]; must satisfy 2^SHW > WIDTH

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted on a rising edge when start=1 and busy=0
op  input  4  opcode, sampled at accept
in1  input  WIDTH  operand A (accumulator side)
in2  input  WIDTH  operand B / shift amount
out  output  WIDTH  registered result
flag_n  output  1  negative flag, out[WIDTH-1]
flag_z  output  1  zero flag, out==0
flag_v  output  1  signed overflow
flag_c  output  1  carry / borrow / shifted-out bit
busy  output  1  multi-cycle op in progress
done  output  1  one-cycle pulse: out and flags updated this cycle
err  output  1  one-cycle pulse with done on an illegal opcode

Behaviour:
- One clock; reset is synchronous and active-low. On a clk edge with rst_n=0: out=0, all flags 0, busy=0, done=0, err=0, FSM=IDLE, stored carry=0. Reset aborts any in-flight op with no done pulse.
- Opcodes:
  - 0000 ADD
  - 0001 SUB
  - 0010 OR
  - 0011 AND
  - 0100 SRL
  - 0101 SLL
  - 0110 NOT (bitwise ~in1)
  - 0111 PASS in1
  - 1000 ADC (in1+in2+C)
  - 1001 SBB (in1-in2-C)
  - 1010 XOR
  - 1011 SRA
  - 1100 MUL (low WIDTH bits of in1*in2, unsigned)
  - 1101-1111 illegal
- Arithmetic rules:
  - ADD/ADC: {C,out} = WIDTH+1-bit sum.
  - SUB/SBB: C = borrow, i.e. 1 iff in1 < in2(+C) unsigned.
  - V = signed overflow: for add, operands have the same sign and the result sign differs; for sub, operands have different signs and the result sign differs from in1.
  - Logic ops and PASS: C=0, V=0.
  - Every op: N=out[MSB], Z=(out==0).
- Single-cycle ops (everything except shifts with amount>0 and MUL):
  - On the accepting edge: out and flags registered, done=1 for the following cycle.
  - busy stays 0.
  - Back-to-back starts are accepted every cycle.
- Shifts:
  - Amount s = in2[SHW-1:0], clamped to WIDTH.
  - s=0: single-cycle; out=in1, C=0.
  - s>0: FSM IDLE->SHIFT. busy=1 from the accepting edge. One bit shifts per edge; after s edges, out is final, done=1, and busy drops on the same edge.
  - C = last bit shifted out. SRA fills with the sign bit. SRL/SLL fill with 0. V=0.
  - Shift by WIDTH: SRL/SLL give 0; SRA gives all sign bits.
- MUL:
  - FSM IDLE->MUL. Exactly WIDTH step edges after accept, then done.
  - C = 1 iff the upper WIDTH bits of the full 2*WIDTH product are nonzero. V=0.
- Illegal op: single-cycle; out=0, flags unchanged except Z=1; done=1, err=1.
- Handshake:
  - start while busy=1 is ignored; no queuing.
  - op/in1/in2 changes after accept have no effect.
  - out and flags hold between done pulses.
  - Intermediate shift/multiply values are internal; out changes only on done.
- Stored carry: updated to flag_c at every done. ADC/SBB read it as of the accept edge.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-MUL -> out=0, flags=0, busy=0, no done. The next start with ADD 1+1 yields out=2.
- WIDTH=8, ADD 0x7F+0x01 -> next cycle out=0x80, N=1, V=1, C=0, Z=0, done=1, busy=0. Then SUB 0x00-0x01 -> out=0xFF, C=1, V=0, N=1.
- Multi-word: ADD 0xFF+0x01 (out=0x00, C=1, Z=1), then ADC 0x00+0x00 -> out=0x01, C=0.
- SRA 0x90 by 3 -> busy high 3 cycles, done on the 3rd step edge, out=0xF2, C=0. SLL 0x81 by 8 -> out=0x00, C=1 (last bit out is bit 0 of the original), 8 step cycles. SRL by 0 -> single-cycle, out=in1.
- MUL 0x10*0x11 -> done exactly 8 step edges after accept, out=0x10, C=1. A start pulsed during busy with op=ADD is ignored (single done pulse).
- Illegal op 0xE -> out=0, Z=1, err=1 and done=1 for one cycle. N/V/C retain their prior values.
